trig_capture: RTL and testbench

Trigger-consuming acquisition block for the 14-bit offset-binary ADC path. It records samples into a circular buffer, holds a programmable pre-trigger history, and completes the post-trigger record after a rising edge on the Schmitt-trigger output. It then streams the full record, in chronological order, to the readout side over a valid/ready handshake. It sits between the ADC/trigger front end and the host readout logic.

---
 rtl/trig_capture_pkg.sv | 19 +
 rtl/trig_capture_ram.sv | 31 +++
 rtl/trig_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_trig_capture.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_capture_pkg.sv
// Shared types and helpers for the trigger-consuming acquisition block.
package trig_capture_pkg;

  localparam int unsigned SAMPLE_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRG,
    ST_POST,
    ST_READ
  } cap_state_t;

  // Offset-binary ADC code to two's complement: flip the MSB.
  function automatic logic signed [SAMPLE_W-1:0] ob2s(input logic [SAMPLE_W-1:0] raw);
    return {~raw[SAMPLE_W-1], raw[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/trig_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module trig_capture_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trig_capture.sv
// Pre/post-trigger capture into a circular buffer, then chronological readout.
// Optional TRIG_CAPTURE_FORCE_EN adds a level-sensitive force_trg input.
module trig_capture
  import trig_capture_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SAMPLE_W-1:0]        ain,
  input  logic                       trg,
  input  logic                       arm,
  input  logic [DEPTH_LOG2-1:0]      pre_len,
`ifdef TRIG_CAPTURE_FORCE_EN
  input  logic                       force_trg,
`endif
  output logic signed [SAMPLE_W-1:0] rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  cap_state_t state_q, state_d;

  logic                trg_dly_q, trg_dly_d;
  logic [AW-1:0]       pl_q, pl_d;
  logic [AW-1:0]       wp_q, wp_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       rem_q, rem_d;
  logic [AW-1:0]       ra_q, ra_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic                ram_vld_q, ram_vld_d;
  logic                ram_last_q, ram_last_d;
  logic                out_vld_q, out_vld_d;
  logic                out_last_q, out_last_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;
  logic                skid_vld_q, skid_vld_d;
  logic                skid_last_q, skid_last_d;
  logic [SAMPLE_W-1:0] skid_data_q, skid_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                trg_edge_c;
  logic                hit_c;
  logic                pop_c;
  logic [1:0]          occ_c;
  logic                issue_c;
  logic                we_c;
  logic [SAMPLE_W-1:0] ram_rdata;

  trig_capture_ram #(
    .ADDR_W(AW),
    .DATA_W(SAMPLE_W)
  ) u_ram (
    .clk  (clk),
    .we   (we_c),
    .waddr(wp_q),
    .wdata(ob2s(ain)),
    .re   (issue_c),
    .raddr(ra_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    trg_dly_d   = trg;
    pl_d        = pl_q;
    wp_d        = wp_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    ra_d        = ra_q;
    rcnt_d      = rcnt_q;
    done_d      = 1'b0;
    we_c        = 1'b0;
    issue_c     = 1'b0;
    trg_edge_c  = trg & ~trg_dly_q;
`ifdef TRIG_CAPTURE_FORCE_EN
    hit_c       = trg_edge_c | force_trg;
`else
    hit_c       = trg_edge_c;
`endif
    pop_c       = out_vld_q & rd_ready;
    // Entries already held or in flight; a new read may issue only if it will fit.
    occ_c       = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q);

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          pl_d    = pre_len;
          wp_d    = '0;
          cnt_d   = '0;
          rcnt_d  = '0;
          state_d = (pre_len == '0) ? ST_WAIT_TRG : ST_PRE;
        end
      end
      ST_PRE: begin
        we_c  = 1'b1;
        wp_d  = wp_q + AW'(1);
        cnt_d = cnt_q + AW'(1);
        if (cnt_d == pl_q) begin
          state_d = ST_WAIT_TRG;
        end
      end
      ST_WAIT_TRG: begin
        we_c = 1'b1;
        wp_d = wp_q + AW'(1);
        if (hit_c) begin
          // Post-trigger count DEPTH-1-pl is just the bitwise complement of pl.
          ra_d    = wp_q - pl_q;
          rem_d   = ~pl_q;
          state_d = (~pl_q == '0) ? ST_READ : ST_POST;
        end
      end
      ST_POST: begin
        we_c  = 1'b1;
        wp_d  = wp_q + AW'(1);
        rem_d = rem_q - AW'(1);
        if (rem_q == AW'(1)) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        issue_c = (rcnt_q < CNT_W'(DEPTH)) && (occ_c <= (2'(pop_c) + 2'd1));
        if (issue_c) begin
          ra_d   = ra_q + AW'(1);
          rcnt_d = rcnt_q + CNT_W'(1);
        end
        if (pop_c && out_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ram_vld_d   = issue_c;
    ram_last_d  = issue_c && (rcnt_q == CNT_W'(DEPTH - 1));
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;

    // Output register refills from the skid first, keeping chronological order.
    if (pop_c || !out_vld_q) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_last_d  = skid_last_q;
        out_data_d  = skid_data_q;
        skid_vld_d  = ram_vld_q;
        skid_last_d = ram_vld_q & ram_last_q;
        if (ram_vld_q) begin
          skid_data_d = ram_rdata;
        end
      end else begin
        out_vld_d  = ram_vld_q;
        out_last_d = ram_vld_q & ram_last_q;
        if (ram_vld_q) begin
          out_data_d = ram_rdata;
        end
      end
    end else if (ram_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_last_d = ram_last_q;
      skid_data_d = ram_rdata;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trg_dly_q   <= 1'b0;
      pl_q        <= '0;
      wp_q        <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      ra_q        <= '0;
      rcnt_q      <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trg_dly_q   <= trg_dly_d;
      pl_q        <= pl_d;
      wp_q        <= wp_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      ra_q        <= ra_d;
      rcnt_q      <= rcnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_vld_q;
  assign rd_last  = out_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_trig_capture.sv
// Directed + randomized bench for trig_capture with a record-level reference model.
module tb_trig_capture;

  localparam int DEPTH = 16;

  logic              clk;
  logic              rst;
  logic [13:0]       ain;
  logic              trg;
  logic              arm;
  logic [3:0]        pre_len;
`ifdef TRIG_CAPTURE_FORCE_EN
  logic              force_trg;
`endif
  logic signed [13:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              busy;
  logic              done;

  trig_capture #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ain      (ain),
    .trg      (trg),
    .arm      (arm),
    .pre_len  (pre_len),
`ifdef TRIG_CAPTURE_FORCE_EN
    .force_trg(force_trg),
`endif
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the record should be, derived from the sample history.
  logic [13:0] s_val;
  logic [13:0] hist[$];
  logic [13:0] exp_q[$];
  int          m_phase;      // 0 idle, 1 capturing, 2 reading out
  int          m_pl;
  int          m_post;
  bit          m_trig;
  bit          m_trg_prev;
  bit          m_done;
  bit          m_rst_seen;
  int          m_xfers;
  int          m_rd_cyc;
  bit          m_seen_valid;
  bit          xfer_pending;
  bit          rdy_rand;
  bit          prev_valid, prev_ready, prev_last;
  logic [13:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_s(input logic [13:0] v);
    s_val = v;
    ain   = {~s_val[13], s_val[12:0]};
  endtask

  // Applies the rules at the coming clock edge to the inputs currently driven.
  task automatic model_eval();
    bit hit;
    if (rst) begin
      m_phase    = 0;
      m_trg_prev = 1'b0;
      m_done     = 1'b0;
      m_rst_seen = 1'b1;
      exp_q.delete();
      hist.delete();
      return;
    end
    m_rst_seen = 1'b0;
    hit = trg && !m_trg_prev;
`ifdef TRIG_CAPTURE_FORCE_EN
    hit = hit || force_trg;
`endif
    m_done = 1'b0;
    case (m_phase)
      0: if (arm) begin
        m_phase = 1;
        m_pl    = int'(pre_len);
        m_trig  = 1'b0;
        m_post  = 0;
        hist.delete();
      end
      1: begin
        hist.push_back(s_val);
        if (m_trig) m_post--;
        else if (hist.size() > m_pl && hit) begin
          m_trig = 1'b1;
          m_post = DEPTH - 1 - m_pl;
        end
        if (m_trig && m_post == 0) begin
          for (int i = hist.size() - DEPTH; i < hist.size(); i++) exp_q.push_back(hist[i]);
          m_phase      = 2;
          m_xfers      = 0;
          m_rd_cyc     = 0;
          m_seen_valid = 1'b0;
        end
      end
      default: if (xfer_pending) begin
        m_xfers++;
        if (m_xfers == DEPTH) begin
          m_phase = 0;
          m_done  = 1'b1;
        end
      end
    endcase
    m_trg_prev = trg;
  endtask

  task automatic check_cycle();
    if (m_rst_seen) begin
      chk("rst_valid", 32'(rd_valid), 32'(0));
      chk("rst_last", 32'(rd_last), 32'(0));
      chk("rst_data", {18'd0, rd_data}, 32'(0));
    end
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_done));
    if (m_phase != 2) begin
      chk("idle_valid", 32'(rd_valid), 32'(0));
    end else begin
      if (!m_seen_valid && rd_valid) begin
        chk("first_valid_latency", 32'(m_rd_cyc), 32'(2));
        m_seen_valid = 1'b1;
      end
      m_rd_cyc++;
    end
    if (!m_rst_seen && prev_valid && !prev_ready) begin
      chk("stall_valid", 32'(rd_valid), 32'(1));
      chk("stall_data", {18'd0, rd_data}, {18'd0, prev_data});
      chk("stall_last", 32'(rd_last), 32'(prev_last));
    end
    if (!m_rst_seen && !rdy_rand && prev_valid && prev_ready && !prev_last) begin
      chk("gapless", 32'(rd_valid), 32'(1));
    end
  endtask

  task automatic step();
    logic [13:0] ev;
    model_eval();
    @(negedge clk);
    check_cycle();
    set_s(s_val + 14'd1);
    rd_ready     = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    xfer_pending = rd_valid && rd_ready;
    if (xfer_pending) begin
      chk("xfer_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        chk("rd_data", {18'd0, rd_data}, {18'd0, ev});
        chk("rd_last", 32'(rd_last), 32'(exp_q.size() == 0));
      end
    end
    prev_valid = rd_valid;
    prev_ready = rd_ready;
    prev_last  = rd_last;
    prev_data  = rd_data;
  endtask

  task automatic wait_s(input logic [13:0] v);
    int n = 0;
    while (s_val != v && n < 20000) begin
      step();
      n++;
    end
    chk("wait_s", 32'(s_val), 32'(v));
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    while (m_phase != 0 && n < 400) begin
      step();
      n++;
    end
    chk(tag, 32'(m_phase), 32'(0));
    step();
    step();
  endtask

  task automatic arm_at(input logic [13:0] s, input logic [3:0] pl);
    pre_len = pl;
    set_s(s);
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; trg = 1'b0; arm = 1'b0; pre_len = '0; rd_ready = 1'b1;
`ifdef TRIG_CAPTURE_FORCE_EN
    force_trg = 1'b0;
`endif
    rdy_rand = 1'b0; xfer_pending = 1'b0; m_phase = 0; m_trig = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_last = 1'b0; prev_data = '0;
    set_s(14'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Basic capture: 96..111
    arm_at(14'd90, 4'd4);
    wait_s(14'd100); trg = 1'b1; step(); step(); trg = 1'b0;
    run_until_idle("s1_idle");

    // Zero pre-trigger with trg already high at arm: 50..65
    trg = 1'b1; set_s(14'd44); step();
    arm_at(14'd45, 4'd0);
    step(); trg = 1'b0;
    wait_s(14'd50); trg = 1'b1; step(); trg = 1'b0;
    run_until_idle("s2_idle");

    // Maximum pre-trigger, early edge ignored: 25..40
    arm_at(14'd20, 4'd15);
    wait_s(14'd23); trg = 1'b1; step(); step(); trg = 1'b0;
    wait_s(14'd40); trg = 1'b1; step(); trg = 1'b0;
    run_until_idle("s3_idle");

    // Backpressure on the scenario-1 record
    rdy_rand = 1'b1;
    arm_at(14'd90, 4'd4);
    wait_s(14'd100); trg = 1'b1; step(); trg = 1'b0;
    run_until_idle("s4_idle");
    rdy_rand = 1'b0;

    // Arm ignored in POST, reset in POST, then a clean record
    arm_at(14'd300, 4'd4);
    wait_s(14'd310); trg = 1'b1; step(); trg = 1'b0;
    step(); step();
    arm = 1'b1; step(); arm = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (3) step();
    arm_at(14'd400, 4'd6);
    wait_s(14'd420); trg = 1'b1; step(); trg = 1'b0;
    run_until_idle("s5_idle");

`ifdef TRIG_CAPTURE_FORCE_EN
    // Forced trigger with trg low: 198..213
    arm_at(14'd190, 4'd2);
    wait_s(14'd200); force_trg = 1'b1; step(); force_trg = 1'b0;
    run_until_idle("s6_idle");
`endif

    // Randomized captures, the first crossing the +8191/-8192 wrap
    for (int r = 0; r < 6; r++) begin
      int tries;
      int gap;
      rdy_rand = 1'($urandom_range(0, 1));
      arm_at((r == 0) ? 14'h1FF0 : 14'($urandom), 4'($urandom_range(0, 15)));
      tries = 0;
      while (m_phase == 1 && !m_trig && tries < 40) begin
        gap = $urandom_range(0, 6);
        repeat (gap) step();
        trg = 1'b1;
        gap = $urandom_range(1, 3);
        repeat (gap) step();
        trg = 1'b0;
        step();
        tries++;
      end
      run_until_idle("rand_idle");
    end
    rdy_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
